// File: rtl/obstacle_scheduler_pkg.sv
// Shared obstacle data types and playfield geometry used by the scheduler and
// the track renderer.
package obstacle_scheduler_pkg;

    localparam int SCREEN_WIDTH   = 640;
    localparam int OBSTACLE_WIDTH = 32;
    localparam int SPAWN_POSITION = SCREEN_WIDTH + OBSTACLE_WIDTH;

    localparam int POSITION_W    = 10;
    localparam int SPRITE_TYPE_W = 3;
    localparam int LANE_W        = 2;

    localparam logic [SPRITE_TYPE_W-1:0] POWERUP_OBSTACLE_TYPE = 3'd4;
    localparam logic [LANE_W-1:0]        INVALID_LANE          = 2'd3;

    typedef struct packed {
        logic                     active;
        logic [LANE_W-1:0]        lane;
        logic [SPRITE_TYPE_W-1:0] sprite_type;
        logic [POSITION_W-1:0]    position;
    } obstacle_t;

    typedef enum logic {
        ST_IDLE,
        ST_UPDATE
    } sched_state_e;

endpackage

// File: rtl/obstacle_scheduler_slot_finder.sv
// Priority encoder returning the lowest-index slot whose active bit is clear.
module obstacle_slot_finder #(
    parameter int NUM_SLOTS = 10
) (
    input  logic [NUM_SLOTS-1:0] active_i,
    output logic                 found_o,
    output logic [3:0]           index_o
);

    // Scan from the top down so the lowest free index is the last one written.
    always_comb begin
        found_o = 1'b0;
        index_o = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!active_i[i]) begin
                found_o = 1'b1;
                index_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle slot manager: accepts spawn requests while idle and, once per frame,
// sweeps every slot one per cycle to scroll obstacles toward the player.
module obstacle_scheduler
    import obstacle_scheduler_pkg::*;
#(
    parameter int NUM_SLOTS = 10
) (
    input  logic                              system_clock_in,
    input  logic                              system_reset_n_in,
    input  logic                              frame_tick,
    input  logic [3:0]                        speed,
    input  logic                              spawn_valid,
    input  logic [LANE_W-1:0]                 spawn_lane,
    input  logic [SPRITE_TYPE_W-1:0]          spawn_sprite_type,
    output logic                              spawn_ready,
    input  logic                              clear_all,
    output obstacle_t [NUM_SLOTS-1:0]         obstacles,
    output logic [3:0]                        active_count,
    output logic                              update_done,
    output logic                              update_overrun
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_SLOTS - 1);

    sched_state_e              state_q;
    logic [3:0]                sweepIdx_q;
    logic [3:0]                speed_q;
    logic [3:0]                activeCount_q;
    logic                      pendingTick_q;
    logic                      updateDone_q;
    logic                      overrun_q;
    obstacle_t [NUM_SLOTS-1:0] slots_q;
    obstacle_t [NUM_SLOTS-1:0] slots_d;

    logic [NUM_SLOTS-1:0]      activeBits;
    logic                      freeFound;
    logic [3:0]                freeIdx;
    logic [3:0]                countNow;
    logic                      spawnAccept;
    obstacle_t                 sweptSlot;

    always_comb begin
        countNow = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            activeBits[i] = slots_q[i].active;
            countNow      = countNow + 4'(slots_q[i].active);
        end
    end

    obstacle_slot_finder #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_slot_finder (
        .active_i (activeBits),
        .found_o  (freeFound),
        .index_o  (freeIdx)
    );

    assign spawn_ready = (state_q == ST_IDLE) && freeFound && !frame_tick
                         && !pendingTick_q && !clear_all;
    assign spawnAccept = spawn_valid && spawn_ready;

    // Slots that cannot absorb a full step retire instead of wrapping below zero.
    always_comb begin
        sweptSlot = slots_q[sweepIdx_q];
        if (sweptSlot.active) begin
            if (sweptSlot.position >= POSITION_W'(speed_q)) begin
                sweptSlot.position = sweptSlot.position - POSITION_W'(speed_q);
            end else begin
                sweptSlot.active   = 1'b0;
                sweptSlot.position = '0;
            end
        end
    end

    always_comb begin
        slots_d = slots_q;
        if (state_q == ST_UPDATE) begin
            slots_d[sweepIdx_q] = sweptSlot;
        end else if (spawnAccept && (spawn_lane != INVALID_LANE)) begin
            slots_d[freeIdx].active      = 1'b1;
            slots_d[freeIdx].lane        = spawn_lane;
            slots_d[freeIdx].sprite_type = spawn_sprite_type;
            slots_d[freeIdx].position    = POSITION_W'(SPAWN_POSITION);
        end
    end

    always_ff @(posedge system_clock_in or negedge system_reset_n_in) begin
        if (!system_reset_n_in) begin
            state_q       <= ST_IDLE;
            sweepIdx_q    <= '0;
            speed_q       <= '0;
            pendingTick_q <= 1'b0;
            updateDone_q  <= 1'b0;
            overrun_q     <= 1'b0;
            activeCount_q <= '0;
            slots_q       <= '0;
        end else begin
            activeCount_q <= countNow;
            updateDone_q  <= 1'b0;
            if (clear_all) begin
                state_q       <= ST_IDLE;
                sweepIdx_q    <= '0;
                pendingTick_q <= 1'b0;
                slots_q       <= '0;
            end else begin
                slots_q <= slots_d;
                case (state_q)
                    ST_IDLE: begin
                        if (frame_tick) begin
                            state_q    <= ST_UPDATE;
                            speed_q    <= speed;
                            sweepIdx_q <= '0;
                        end
                    end
                    ST_UPDATE: begin
                        if (frame_tick && pendingTick_q) begin
                            overrun_q <= 1'b1;
                        end
                        if (sweepIdx_q == LAST_IDX) begin
                            updateDone_q  <= 1'b1;
                            pendingTick_q <= 1'b0;
                            sweepIdx_q    <= '0;
                            // A tick landing on the final slot chains straight into the next sweep.
                            if (pendingTick_q || frame_tick) begin
                                state_q <= ST_UPDATE;
                                speed_q <= speed;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            sweepIdx_q <= sweepIdx_q + 4'd1;
                            if (frame_tick) begin
                                pendingTick_q <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign obstacles      = slots_q;
    assign active_count   = activeCount_q;
    assign update_done    = updateDone_q;
    assign update_overrun = overrun_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler: spawning, sweeping, retirement,
// back-to-back and dropped ticks, clear_all and mid-sweep reset.
module tb_obstacle_scheduler;
    import obstacle_scheduler_pkg::*;

    localparam int NUM_SLOTS = 10;

    logic                      clock;
    logic                      resetN;
    logic                      frameTick;
    logic [3:0]                speed;
    logic                      spawnValid;
    logic [LANE_W-1:0]         spawnLane;
    logic [SPRITE_TYPE_W-1:0]  spawnType;
    logic                      spawnReady;
    logic                      clearAll;
    obstacle_t [NUM_SLOTS-1:0] obstacles;
    logic [3:0]                activeCount;
    logic                      updateDone;
    logic                      updateOverrun;

    int total;
    int bad;

    obstacle_scheduler #(
        .NUM_SLOTS (NUM_SLOTS)
    ) dut (
        .system_clock_in   (clock),
        .system_reset_n_in (resetN),
        .frame_tick        (frameTick),
        .speed             (speed),
        .spawn_valid       (spawnValid),
        .spawn_lane        (spawnLane),
        .spawn_sprite_type (spawnType),
        .spawn_ready       (spawnReady),
        .clear_all         (clearAll),
        .obstacles         (obstacles),
        .active_count      (activeCount),
        .update_done       (updateDone),
        .update_overrun    (updateOverrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [1:0] lane,
                                 input logic [2:0] sprite, input logic tick,
                                 input logic [3:0] spd, input logic clr);
        spawnValid = valid;
        spawnLane  = lane;
        spawnType  = sprite;
        frameTick  = tick;
        speed      = spd;
        clearAll   = clr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic waitSweepDone(input int budget);
        int n = 0;
        while (updateDone !== 1'b1 && n < budget) begin
            cyc();
            n++;
        end
        checkOutput("sweepDone", 32'(updateDone), 1);
    endtask

    task automatic doSweep(input logic [3:0] spd);
        frameTick = 1'b1;
        speed     = spd;
        cyc();
        frameTick = 1'b0;
        waitSweepDone(12);
    endtask

    initial begin
        obstacle_t [NUM_SLOTS-1:0] snap;
        logic sawDone;
        total  = 0;
        bad    = 0;
        resetN = 1'b0;
        applyStimulus(0, 2'd0, 3'd0, 0, 4'd0, 0);
        #3;
        checkOutput("rstCount", 32'(activeCount), 0);
        checkOutput("rstDone", 32'(updateDone), 0);
        checkOutput("rstOverrun", 32'(updateOverrun), 0);
        checkOutput("rstSlots", 32'(obstacles === '0), 1);
        #14 resetN = 1'b1;
        cyc();

        applyStimulus(1, 2'd1, 3'd0, 0, 4'd0, 0);
        #1;
        checkOutput("readyIdle", 32'(spawnReady), 1);
        cyc();
        spawnValid = 1'b0;
        checkOutput("spawnActive", 32'(obstacles[0].active), 1);
        checkOutput("spawnLane", 32'(obstacles[0].lane), 1);
        checkOutput("spawnPos", 32'(obstacles[0].position), 672);
        checkOutput("countLag", 32'(activeCount), 0);
        cyc();
        checkOutput("countOne", 32'(activeCount), 1);

        applyStimulus(1, 2'd3, 3'd1, 0, 4'd0, 0);
        #1;
        checkOutput("lane3Ready", 32'(spawnReady), 1);
        snap = obstacles;
        cyc();
        spawnValid = 1'b0;
        checkOutput("lane3NoWrite", 32'(obstacles === snap), 1);
        cyc();
        checkOutput("lane3Count", 32'(activeCount), 1);

        for (int i = 0; i < 44; i++) doSweep(4'd15);
        checkOutput("pos12", 32'(obstacles[0].position), 12);
        doSweep(4'd7);
        checkOutput("pos5", 32'(obstacles[0].position), 5);
        doSweep(4'd3);
        checkOutput("pos2", 32'(obstacles[0].position), 2);
        checkOutput("pos2Active", 32'(obstacles[0].active), 1);

        applyStimulus(1, 2'd1, 3'd3, 0, 4'd0, 0);
        repeat (9) cyc();
        applyStimulus(1, 2'd2, 3'd5, 0, 4'd0, 0);
        #1;
        checkOutput("fullNotReady", 32'(spawnReady), 0);
        snap = obstacles;
        repeat (3) cyc();
        checkOutput("fullHeld", 32'(obstacles === snap), 1);
        checkOutput("fullCount", 32'(activeCount), 10);
        checkOutput("slot9Type", 32'(obstacles[9].sprite_type), 3);
        checkOutput("slot9Pos", 32'(obstacles[9].position), 672);

        frameTick = 1'b1;
        speed     = 4'd3;
        cyc();
        frameTick = 1'b0;
        waitSweepDone(12);
        checkOutput("retireActive", 32'(obstacles[0].active), 0);
        checkOutput("retirePos", 32'(obstacles[0].position), 0);
        checkOutput("slot1Pos", 32'(obstacles[1].position), 669);
        checkOutput("readyAfterRetire", 32'(spawnReady), 1);
        cyc();
        spawnValid = 1'b0;
        checkOutput("heldLands", 32'(obstacles[0].active), 1);
        checkOutput("heldLane", 32'(obstacles[0].lane), 2);
        checkOutput("heldType", 32'(obstacles[0].sprite_type), 5);
        checkOutput("heldPos", 32'(obstacles[0].position), 672);

        speed     = 4'd1;
        frameTick = 1'b1;
        cyc();
        frameTick = 1'b0;
        repeat (3) cyc();
        frameTick = 1'b1;
        cyc();
        frameTick = 1'b0;
        checkOutput("noOverrunYet", 32'(updateOverrun), 0);
        cyc();
        frameTick = 1'b1;
        cyc();
        frameTick = 1'b0;
        checkOutput("overrunSet", 32'(updateOverrun), 1);
        repeat (4) cyc();
        checkOutput("firstDone", 32'(updateDone), 1);
        repeat (9) cyc();
        checkOutput("noEarlyDone", 32'(updateDone), 0);
        cyc();
        checkOutput("secondDone", 32'(updateDone), 1);
        checkOutput("slot5Twice", 32'(obstacles[5].position), 667);
        checkOutput("slot0Twice", 32'(obstacles[0].position), 670);

        frameTick = 1'b1;
        cyc();
        frameTick = 1'b0;
        repeat (4) cyc();
        clearAll = 1'b1;
        #1;
        checkOutput("clearNotReady", 32'(spawnReady), 0);
        cyc();
        clearAll = 1'b0;
        checkOutput("clearSlots", 32'(obstacles === '0), 1);
        checkOutput("clearNoDone", 32'(updateDone), 0);
        checkOutput("clearKeepsOverrun", 32'(updateOverrun), 1);
        sawDone = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            sawDone = sawDone | updateDone;
        end
        checkOutput("abortedNoDone", 32'(sawDone), 0);
        checkOutput("clearIdleReady", 32'(spawnReady), 1);
        checkOutput("clearCount", 32'(activeCount), 0);

        applyStimulus(1, 2'd0, 3'd2, 1, 4'd1, 0);
        #1;
        checkOutput("tickBeatsSpawn", 32'(spawnReady), 0);
        cyc();
        frameTick = 1'b0;
        waitSweepDone(12);
        checkOutput("readyOnDone", 32'(spawnReady), 1);
        checkOutput("notYetSpawned", 32'(obstacles[0].active), 0);
        cyc();
        spawnValid = 1'b0;
        checkOutput("lateSpawn", 32'(obstacles[0].active), 1);
        checkOutput("lateType", 32'(obstacles[0].sprite_type), 2);
        checkOutput("latePos", 32'(obstacles[0].position), 672);

        frameTick = 1'b1;
        cyc();
        frameTick = 1'b0;
        repeat (3) cyc();
        resetN = 1'b0;
        #2;
        checkOutput("midRstSlots", 32'(obstacles === '0), 1);
        checkOutput("midRstCount", 32'(activeCount), 0);
        checkOutput("midRstOverrun", 32'(updateOverrun), 0);
        checkOutput("midRstDone", 32'(updateDone), 0);
        #2 resetN = 1'b1;
        cyc();
        checkOutput("postRstReady", 32'(spawnReady), 1);
        checkOutput("postRstDone", 32'(updateDone), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/obstacle_scheduler.md
OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

Interface
REQ-001 Parameter NUM_SLOTS, default 10, number of obstacle slots driven to the renderer.
REQ-002 system_clock_in  input  1  sole clock; all state updates on its rising edge.
REQ-003 system_reset_n_in  input  1  asynchronous, active-low reset.
REQ-004 frame_tick  input  1  one-cycle pulse per frame; starts a movement sweep.
REQ-005 speed  input  4  pixels per frame; sampled on the accepted frame_tick.
REQ-006 spawn_valid  input  1  spawn request.
REQ-007 spawn_lane  input  2  lane of the request, 0..2.
REQ-008 spawn_sprite_type  input  sprite-type width from package  sprite of the request.
REQ-009 spawn_ready  output  1  high when a request can be accepted this cycle.
REQ-010 clear_all  input  1  one-cycle pulse; empties every slot.
REQ-011 obstacles  output  obstacle [NUM_SLOTS-1:0]  registered slot array consumed by the track renderer.
REQ-012 active_count  output  4  number of slots with active=1.
REQ-013 update_done  output  1  one-cycle pulse when a sweep finishes.
REQ-014 update_overrun  output  1  sticky flag: a frame_tick was dropped.

Function
REQ-015 States: IDLE, UPDATE; slot index register sweep_idx, 4 bits.
REQ-016 Entering UPDATE: from IDLE on frame_tick, or from the end of a sweep when pending_tick=1; latch speed into speed_q and set sweep_idx=0.
REQ-017 UPDATE, one slot per cycle:
- if active and position >= speed_q: position -= speed_q.
- if active and position < speed_q: active=0, position=0 (retire, no underflow).
- inactive slots are unchanged.
REQ-018 A sweep takes exactly NUM_SLOTS cycles.
REQ-019 Cycle after slot NUM_SLOTS-1 is processed:
- update_done pulses.
- next state = UPDATE if pending_tick, else IDLE; pending_tick is cleared.
REQ-020 frame_tick during UPDATE:
- sets pending_tick if it is clear.
- if pending_tick is already set, the tick is dropped and update_overrun is set.
REQ-021 spawn_ready = IDLE AND free slot exists AND NOT frame_tick AND NOT pending_tick AND NOT clear_all (combinational).
REQ-022 Handshake: accepted when spawn_valid and spawn_ready are both high. The accepted request writes the lowest-index inactive slot on the next edge: active=1, lane=spawn_lane, sprite_type=spawn_sprite_type, position=SPAWN_POSITION.
REQ-023 At most one spawn per cycle.
REQ-024 spawn_lane=3 is ignored: no write, and spawn_ready still completes the handshake.
REQ-025 frame_tick together with spawn_valid in IDLE: the tick wins, and the spawn waits until spawn_ready returns.
REQ-026 clear_all has highest priority, in any state:
- next edge: all slots zeroed, state IDLE, pending_tick cleared.
- no update_done for the aborted sweep.
- update_overrun unchanged.
REQ-027 All slots full: spawn_ready=0; the request is held and not lost.
REQ-028 active_count is registered and equals the popcount of active bits the cycle after any change.

Reset
REQ-029 While system_reset_n_in=0, all of the following hold:
- every slot has active=0, lane=0, sprite_type=0, position=0.
- state=IDLE, sweep_idx=0, speed_q=0, pending_tick=0.
- active_count=0, update_done=0, update_overrun=0.
REQ-030 Reset asserted mid-sweep aborts immediately. After release, the block is in IDLE with spawn_ready=1, provided no frame_tick or clear_all is present.

Structure
REQ-031 The obstacle struct, SCREEN_WIDTH, OBSTACLE_WIDTH, POWERUP_OBSTACLE_TYPE and new SPAWN_POSITION (= SCREEN_WIDTH + OBSTACLE_WIDTH) live in the shared data package.
REQ-032 The lowest-index free-slot priority encoder is the sub-module obstacle_slot_finder:
- input: NUM_SLOTS active bits.
- outputs: found, 4-bit index.

Verification
REQ-033 Reset release, spawn_valid lane=1 type=0 -> slot 0 active, lane 1, position=SPAWN_POSITION; active_count=1 one cycle later.
REQ-034 Slot 0 position=5, speed=3, frame_tick -> position 2; after update_done, second tick -> slot 0 retired (active=0, position=0).
REQ-035 Spawn 10 requests, then an 11th -> spawn_ready=0 and slot array unchanged; next retire -> 11th request lands in the freed slot.
REQ-036 frame_tick at sweep cycle 3, another at cycle 5 -> second sweep starts immediately after the first; update_overrun=1.
REQ-037 clear_all at sweep cycle 4 -> next cycle all slots inactive, IDLE, no update_done.
REQ-038 frame_tick and spawn_valid in the same IDLE cycle -> spawn_ready=0 that cycle; spawn accepted the cycle after update_done.
